// File: rtl/vend_credit_controller_if.sv
// rtl/vend_credit_controller_if.sv - coin/keypad front end and actuator signal bundle
interface vend_credit_controller_if #(
  parameter int N_PROD = 4,
  parameter int CW     = 8
);
  localparam int IW = (N_PROD > 1) ? $clog2(N_PROD) : 1;

  logic                 coin_valid;
  logic [CW-1:0]        coin_value;
  logic                 sel_valid;
  logic [IW-1:0]        sel_idx;
  logic [N_PROD*CW-1:0] price_table;
  logic                 buy_more;
  logic                 cancel;
  logic                 restock;

  logic                 dispense;
  logic [IW-1:0]        dispense_idx;
  logic                 change_valid;
  logic [CW-1:0]        change;
  logic                 insufficient;
  logic                 sold_out;
  logic                 coin_reject;
  logic [CW-1:0]        credit;
  logic [N_PROD-1:0]    stock_empty;
  logic                 busy;

  modport master (
    output coin_valid, coin_value, sel_valid, sel_idx, price_table,
           buy_more, cancel, restock,
    input  dispense, dispense_idx, change_valid, change, insufficient,
           sold_out, coin_reject, credit, stock_empty, busy
  );

  modport slave (
    input  coin_valid, coin_value, sel_valid, sel_idx, price_table,
           buy_more, cancel, restock,
    output dispense, dispense_idx, change_valid, change, insufficient,
           sold_out, coin_reject, credit, stock_empty, busy
  );
endinterface

// File: rtl/vend_credit_controller.sv
// rtl/vend_credit_controller.sv - multi-purchase coin credit controller with price table and stock
module vend_credit_controller #(
  parameter int N_PROD     = 4,
  parameter int CW         = 8,
  parameter int MAX_CREDIT = 200,
  parameter int TIMEOUT    = 1000,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8
) (
  input logic clk,
  input logic reset,
  vend_credit_controller_if.slave bus
);
  localparam int IW = $clog2(N_PROD);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]      T_LAST  = TW'(TIMEOUT - 1);
  localparam logic [CW:0]        MAX_W   = (CW + 1)'(MAX_CREDIT);
  localparam logic [STOCK_W-1:0] S_INIT  = STOCK_W'(STOCK_INIT);
  localparam logic [N_PROD-1:0]  E_INIT  = {N_PROD{STOCK_INIT == 0}};

  typedef enum logic [2:0] {IDLE, CREDIT, CHECK, VEND, REFUND} state_t;

  state_t             state;
  logic [CW-1:0]      credit_q;
  logic [CW-1:0]      price_q;
  logic [IW-1:0]      idx_q;
  logic [TW-1:0]      timer;
  logic [STOCK_W-1:0] stock [N_PROD];

  logic               dispense_q, change_valid_q, insufficient_q, sold_out_q, coin_reject_q, busy_q;
  logic [IW-1:0]      dispense_idx_q;
  logic [CW-1:0]      change_q;
  logic [N_PROD-1:0]  stock_empty_q;

  logic [CW-1:0]      price [N_PROD];

  for (genvar i = 0; i < N_PROD; i++) begin : g_price
    assign price[i] = bus.price_table[i*CW +: CW];
  end

  // Credit arithmetic is one bit wider so an overflowing coin is seen, not wrapped.
  logic [CW:0]   coin_sum;
  logic          coin_fits, coin_ok_idle, sel_dead, chk_dead, chk_short;
  logic [CW-1:0] remain;

  assign coin_sum     = {1'b0, credit_q} + {1'b0, bus.coin_value};
  assign coin_fits    = coin_sum <= MAX_W;
  assign coin_ok_idle = (bus.coin_value != '0) && ({1'b0, bus.coin_value} <= MAX_W);
  assign sel_dead     = (price[bus.sel_idx] == '0) || (stock[bus.sel_idx] == '0);
  assign chk_dead     = (price[idx_q] == '0) || (stock[idx_q] == '0);
  assign chk_short    = credit_q < price[idx_q];
  assign remain       = credit_q - price_q;

  // Session FSM: all outputs are registered; pulse outputs default low every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      credit_q       <= '0;
      price_q        <= '0;
      idx_q          <= '0;
      timer          <= '0;
      for (int i = 0; i < N_PROD; i++) stock[i] <= S_INIT;
      stock_empty_q  <= E_INIT;
      dispense_q     <= 1'b0;
      dispense_idx_q <= '0;
      change_valid_q <= 1'b0;
      change_q       <= '0;
      insufficient_q <= 1'b0;
      sold_out_q     <= 1'b0;
      coin_reject_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      dispense_q     <= 1'b0;
      change_valid_q <= 1'b0;
      change_q       <= '0;
      insufficient_q <= 1'b0;
      sold_out_q     <= 1'b0;
      coin_reject_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.coin_valid) begin
            if (coin_ok_idle) begin
              credit_q <= bus.coin_value;
              timer    <= '0;
              state    <= CREDIT;
              busy_q   <= 1'b1;
            end else begin
              coin_reject_q <= 1'b1;
            end
          end
          if (bus.sel_valid) begin
            if (sel_dead) sold_out_q <= 1'b1;
            else          insufficient_q <= 1'b1;
          end
          if (bus.restock) begin
            for (int i = 0; i < N_PROD; i++) stock[i] <= S_INIT;
            stock_empty_q <= E_INIT;
          end
        end
        CREDIT: begin
          if (bus.coin_valid) begin
            if (coin_fits) credit_q <= coin_sum[CW-1:0];
            else           coin_reject_q <= 1'b1;
          end
          if (bus.cancel) begin
            timer <= '0;
            state <= REFUND;
          end else if (bus.sel_valid) begin
            idx_q <= bus.sel_idx;
            timer <= '0;
            state <= CHECK;
          end else if (bus.coin_valid) begin
            timer <= '0;
          end else if (timer == T_LAST) begin
            timer <= '0;
            state <= REFUND;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        CHECK: begin
          coin_reject_q <= bus.coin_valid;
          price_q       <= price[idx_q];
          if (chk_dead) begin
            sold_out_q <= 1'b1;
            state      <= CREDIT;
          end else if (chk_short) begin
            insufficient_q <= 1'b1;
            state          <= CREDIT;
          end else begin
            state <= VEND;
          end
        end
        VEND: begin
          coin_reject_q         <= bus.coin_valid;
          dispense_q            <= 1'b1;
          dispense_idx_q        <= idx_q;
          credit_q              <= remain;
          stock[idx_q]          <= stock[idx_q] - STOCK_W'(1);
          stock_empty_q[idx_q]  <= (stock[idx_q] == STOCK_W'(1));
          if (remain == '0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (bus.buy_more) begin
            timer <= '0;
            state <= CREDIT;
          end else begin
            state <= REFUND;
          end
        end
        REFUND: begin
          coin_reject_q  <= bus.coin_valid;
          change_valid_q <= 1'b1;
          change_q       <= credit_q;
          credit_q       <= '0;
          state          <= IDLE;
          busy_q         <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dispense     = dispense_q;
  assign bus.dispense_idx = dispense_idx_q;
  assign bus.change_valid = change_valid_q;
  assign bus.change       = change_q;
  assign bus.insufficient = insufficient_q;
  assign bus.sold_out     = sold_out_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.credit       = credit_q;
  assign bus.stock_empty  = stock_empty_q;
  assign bus.busy         = busy_q;
endmodule

// File: doc/vend_credit_controller.md
Name: vend_credit_controller

Overview:
- Parametrised successor to the single-shot money manager.
- Accumulates coin credit over multiple cycles against a runtime-loadable price table for N_PROD products, with per-product stock counters.
- Supports multi-purchase sessions, cancel/refund, overflow coin rejection and an inactivity timeout.
- Sits between the coin acceptor / keypad front end and the dispense and change actuators.

Parameters:
- N_PROD, 4: number of products; must be >= 2.
- CW, 8: credit, coin and price width in bits.
- MAX_CREDIT, 200: upper limit on held credit; must be <= 2^CW-1.
- TIMEOUT, 1000: idle cycles in CREDIT before an automatic refund; must be >= 1.
- STOCK_W, 4: stock counter width.
- STOCK_INIT, 8: stock value loaded on reset and on restock; must be <= 2^STOCK_W-1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- coin_valid  in  1  one-cycle coin strobe.
- coin_value  in  CW  value of the coin; valid with coin_valid.
- sel_valid  in  1  one-cycle product-select strobe.
- sel_idx  in  $clog2(N_PROD)  selected product index.
- price_table  in  N_PROD*CW  product i price at bits [i*CW +: CW]; price 0 means product disabled.
- buy_more  in  1  sampled at vend; 1 keeps the session open.
- cancel  in  1  requests a refund of the held credit.
- restock  in  1  reloads all stock counters to STOCK_INIT.
- dispense  out  1  one-cycle vend pulse.
- dispense_idx  out  $clog2(N_PROD)  product being vended; valid with dispense.
- change_valid  out  1  one-cycle change pulse.
- change  out  CW  change amount; valid with change_valid, otherwise 0.
- insufficient  out  1  one-cycle pulse: credit below price.
- sold_out  out  1  one-cycle pulse: stock is 0 or product disabled.
- coin_reject  out  1  one-cycle pulse: coin not accepted.
- credit  out  CW  currently held credit.
- stock_empty  out  N_PROD  bit i = 1 when stock[i] == 0.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset low, asynchronous): state = IDLE; credit = 0; all pulse outputs = 0; change = 0; dispense_idx = 0; timeout counter = 0; all stock counters = STOCK_INIT. Held credit is discarded with no change pulse.
- All outputs are registered. Pulses are high for exactly one cycle.
- States: IDLE, CREDIT, CHECK, VEND, REFUND.
- IDLE:
  - coin_valid with coin_value in 1..MAX_CREDIT: credit <= coin_value; go to CREDIT.
  - coin_value = 0 or coin_value > MAX_CREDIT: coin_reject pulse; stay in IDLE.
  - sel_valid: insufficient pulse (sold_out instead if the product is disabled or its stock is 0).
  - restock is honoured only in IDLE. In all other states it is ignored.
- CREDIT:
  - Coin accepted when credit + coin_value <= MAX_CREDIT. The sum is computed at CW+1 bits to avoid wrap.
  - Rejected coin: coin_reject pulse; credit unchanged.
  - sel_valid: latch sel_idx and go to CHECK. Any coin arriving in the same cycle is added first.
  - cancel: go to REFUND. Cancel has priority over sel_valid; a same-cycle coin is still added and refunded.
  - Timeout counter clears on any coin_valid or sel_valid; otherwise it increments. When it reaches TIMEOUT, go to REFUND.
- CHECK (1 cycle), with p = price_table[idx]:
  - p == 0 or stock[idx] == 0: sold_out pulse; return to CREDIT.
  - Else credit < p: insufficient pulse; return to CREDIT.
  - Else: go to VEND.
  - Price is sampled in CHECK; price_table changes after CHECK do not affect the vend.
- VEND (1 cycle):
  - dispense = 1 and dispense_idx = idx.
  - credit <= credit - p; stock[idx] <= stock[idx] - 1.
  - Next state: remaining credit == 0 goes to IDLE; else buy_more = 1 goes to CREDIT with the timer cleared; else REFUND.
- REFUND (1 cycle): change_valid = 1 and change = credit; credit <= 0; next state IDLE.
- Coins arriving in CHECK, VEND or REFUND: coin_reject pulse.
- sel_valid and cancel outside the states above are ignored.
- Latency:
  - dispense asserts 2 cycles after the edge that samples sel_valid.
  - insufficient and sold_out assert 1 cycle after that edge.
  - change_valid asserts 1 cycle after the edge that samples cancel.
- Invariant: credit never exceeds MAX_CREDIT. No path changes credit except an accepted coin, a vend or a refund.

Test Plan (N_PROD=4, CW=8, MAX_CREDIT=200, STOCK_INIT=2, TIMEOUT=16, prices 25/50/75/100):
1. Coins 25, 25; sel_idx=1; buy_more=0 -> dispense with idx 1 exactly 2 cycles after sel; credit 0; no change_valid; state IDLE; stock[1] = 1.
2. Coin 100; sel 0 with buy_more=1 -> dispense, credit 75, state CREDIT; sel 2 with buy_more=0 -> dispense idx 2, credit 0, state IDLE, no change pulse.
3. Coin 50; sel 2 -> insufficient, credit stays 50; coin 25; sel 2 -> dispense idx 2; credit 0.
4. Coins 100, 100, 25 -> third coin gets coin_reject, credit 200; cancel -> change_valid with change = 200 one cycle later; credit 0.
5. Two vends of product 3 (coins 100, 100, buy_more=1, then buy_more=0) -> stock_empty[3] = 1. Coin 100; sel 3 -> sold_out, credit 100; restock ignored while in CREDIT; cancel -> change 100; restock in IDLE -> stock_empty[3] = 0.
6. Timeout and reset:
   - Coin 50 then no activity -> change_valid with change = 50 after 16 idle cycles.
   - Coin 75 then reset low mid-session -> all outputs 0 immediately, credit 0, stock reloaded to 2, no change pulse.
